// File: rtl/aes128_decrypt_iter_if.sv
// aes128_decrypt_iter_if: ciphertext/key request and plaintext response handshakes
interface aes128_decrypt_iter_if;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [0:127] ciphertext, key, plaintext;
   modport master(output in_valid, ciphertext, key, out_ready, input in_ready, out_valid, plaintext, busy);
   modport slave(input in_valid, ciphertext, key, out_ready, output in_ready, out_valid, plaintext, busy);
endinterface

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one round per clock,
// with on-chip key expansion and a single-entry round-key cache.
package aes128_decrypt_iter_pkg;
   function automatic logic [7:0] xt(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xt(x);
      end
      return p;
   endfunction
   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] ginv(logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction
   function automatic logic [7:0] rotl(logic [7:0] x, int n);
      return (x << n) | (x >> (8 - n));
   endfunction
   function automatic logic [7:0] rcon(logic [3:0] n);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 1; i < 10; i++) r = (i < int'(n)) ? xt(r) : r;
      return r;
   endfunction
endpackage

module aes_sbox
   import aes128_decrypt_iter_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] v;
   assign v = ginv(a);
   assign y = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
endmodule

module aes_inv_sbox
   import aes128_decrypt_iter_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   assign y = ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
endmodule

module aes128_decrypt_iter
   import aes128_decrypt_iter_pkg::*;
#(
   parameter int KEY_CACHE = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   aes128_decrypt_iter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} state_t;
   localparam logic [7:0] MIX [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
   state_t       st, st_nx;
   logic [0:127] rk [0:10];
   logic [0:127] s, pt, prev, nrk, isr, isb, ark, imc, rnd;
   logic [0:31]  rot, sw, t;
   logic [3:0]   cnt;
   logic         cv, hit;
   assign hit = KEY_CACHE != 0 && cv && bus.key == rk[0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else st <= st_nx;
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    st_nx = bus.in_valid ? (hit ? INIT : KEXP) : IDLE;
         KEXP:    st_nx = cnt == 4'd10 ? INIT : KEXP;
         INIT:    st_nx = ROUND;
         ROUND:   st_nx = cnt == 4'd0 ? DONE : ROUND;
         DONE:    st_nx = bus.out_ready ? IDLE : DONE;
         default: st_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.in_ready  = st == IDLE;
      bus.busy      = st != IDLE;
      bus.out_valid = st == DONE;
   end
   assign bus.plaintext = pt;
   // Key schedule step: rk[cnt] from rk[cnt-1]
   assign prev = rk[cnt - 4'd1];
   assign rot  = {prev[104:127], prev[96:103]};
   assign t    = sw ^ {rcon(cnt), 24'h0};
   always_comb begin
      nrk = '0;
      nrk[0:31]   = prev[0:31] ^ t;
      nrk[32:63]  = prev[32:63] ^ nrk[0:31];
      nrk[64:95]  = prev[64:95] ^ nrk[32:63];
      nrk[96:127] = prev[96:127] ^ nrk[64:95];
   end
   for (genvar i = 0; i < 4; i++) begin : g_fwd
      aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sw[8*i +: 8]));
   end
   always_comb begin
      isr = '0;
      for (int b = 0; b < 16; b++) isr[8*b +: 8] = s[8*(4*((b/4 + 4 - b%4) % 4) + b%4) +: 8];
   end
   for (genvar i = 0; i < 16; i++) begin : g_inv
      aes_inv_sbox u_isbox (.a(isr[8*i +: 8]), .y(isb[8*i +: 8]));
   end
   assign ark = isb ^ rk[cnt];
   always_comb begin
      imc = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
               imc[32*c + 8*r +: 8] = imc[32*c + 8*r +: 8] ^ gmul(MIX[(k + 4 - r) % 4], ark[32*c + 8*k +: 8]);
   end
   assign rnd = cnt == 4'd0 ? ark : imc;
   always_ff @(posedge clk)
      if (st == IDLE && bus.in_valid) rk[0] <= bus.key;
      else if (st == KEXP) rk[cnt] <= nrk;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s   <= '0;
         pt  <= '0;
         cnt <= '0;
         cv  <= 1'b0;
      end else
         case (st)
            IDLE:
               if (bus.in_valid) begin
                  s   <= bus.ciphertext;
                  cnt <= 4'd1;
                  cv  <= hit;
               end
            KEXP: begin
               cnt <= cnt + 4'd1;
               cv  <= cnt == 4'd10;
            end
            INIT: begin
               s   <= s ^ rk[10];
               cnt <= 4'd9;
            end
            ROUND: begin
               s   <= rnd;
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) pt <= rnd;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: directed FIPS-197 / SP800-38A vectors, latency, backpressure,
// mid-round reset and a cache-disabled instance.
module tb_aes128_decrypt_iter;
   logic clk = 0, rst_n = 1;
   always #5 clk = ~clk;
   aes128_decrypt_iter_if a();
   aes128_decrypt_iter_if b();
   aes128_decrypt_iter #(.KEY_CACHE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
   aes128_decrypt_iter #(.KEY_CACHE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
   logic         sel = 0, iv = 0, ordy = 0;
   logic [0:127] k = '0, ct = '0;
   logic         ov, ir, bz;
   logic [0:127] pt;
   assign a.in_valid   = iv && !sel;
   assign b.in_valid   = iv && sel;
   assign a.out_ready  = ordy && !sel;
   assign b.out_ready  = ordy && sel;
   assign a.key        = k;
   assign b.key        = k;
   assign a.ciphertext = ct;
   assign b.ciphertext = ct;
   assign ov = sel ? b.out_valid : a.out_valid;
   assign ir = sel ? b.in_ready : a.in_ready;
   assign bz = sel ? b.busy : a.busy;
   assign pt = sel ? b.plaintext : a.plaintext;

   localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] PB = 128'h3243f6a8885a308d313198a2e0370734;

   typedef struct {
      logic [0:127] key, ct, pt;
      int           lat;
   } vec_t;
   vec_t tv[7];
   int errs = 0, checks = 0, lat;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic start_block(input logic [0:127] kk, input logic [0:127] cc, output int l);
      @(negedge clk);
      k  = kk;
      ct = cc;
      iv = 1;
      @(posedge clk);
      #1 iv = 0;
      l = 0;
      do begin
         @(posedge clk);
         #1 l++;
      end while (!ov && l < 40);
   endtask

   task automatic drain();
      @(negedge clk);
      ordy = 1;
      @(posedge clk);
      #1 ordy = 0;
   endtask

   initial begin
      tv[0] = '{K1, C1, P1, 21};
      tv[1] = '{K1, C1, P1, 11};
      tv[2] = '{KB, CB, PB, 21};
      tv[3] = '{K1, C1, P1, 21};
      tv[4] = '{KB, CB, PB, 21};
      tv[5] = '{KB, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a, 11};
      tv[6] = '{KB, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 11};
      #3 rst_n = 0;
      #20;
      chk("rst_in_ready", ir, 1);
      chk("rst_out_valid", ov, 0);
      chk("rst_busy", bz, 0);
      chk("rst_plaintext", pt, 0);
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 7; i++) begin
         start_block(tv[i].key, tv[i].ct, lat);
         chk($sformatf("vec%0d_pt", i), pt, tv[i].pt);
         chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
         drain();
      end
      start_block(KB, CB, lat);
      chk("bp_lat", lat, 11);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         iv = (j % 2) == 0;
         k  = K1;
         ct = C1 ^ 128'(j);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_pt", j), pt, PB);
         chk($sformatf("bp%0d_out_valid", j), ov, 1);
         chk($sformatf("bp%0d_in_ready", j), ir, 0);
         chk($sformatf("bp%0d_busy", j), bz, 1);
      end
      @(negedge clk);
      iv   = 0;
      ordy = 1;
      @(posedge clk);
      #1 ordy = 0;
      chk("bp_release_out_valid", ov, 0);
      chk("bp_release_in_ready", ir, 1);
      @(negedge clk);
      k  = KB;
      ct = CB;
      iv = 1;
      @(posedge clk);
      #1 iv = 0;
      repeat (5) @(posedge clk);
      #2;
      chk("mid_busy", bz, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_in_ready", ir, 1);
      chk("mid_rst_out_valid", ov, 0);
      chk("mid_rst_busy", bz, 0);
      chk("mid_rst_plaintext", pt, 0);
      @(negedge clk) rst_n = 1;
      start_block(KB, CB, lat);
      chk("post_rst_pt", pt, PB);
      chk("post_rst_lat", lat, 21);
      drain();
      sel = 1;
      for (int i = 0; i < 2; i++) begin
         start_block(K1, C1, lat);
         chk($sformatf("nocache%0d_pt", i), pt, P1);
         chk($sformatf("nocache%0d_lat", i), lat, 21);
         drain();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
